// File: rtl/control_sequencer.sv
// Four-cycle instruction sequencer (FETCH, LOAD, READ, EXEC) that drives datapath strobes
// from the latched instruction register and halts when the PC runs off the end of the program.
module control_sequencer #(
  parameter int unsigned PROG_LEN = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] prog_data,
  input  logic       zero_flag,
  output logic [7:0] prog_addr,
  output logic [3:0] ram_addr,
  output logic       ram_re,
  output logic       ram_we,
  output logic [3:0] imm,
  output logic [1:0] alu_op,
  output logic       alu_en,
  output logic [1:0] acc_load,
  output logic [1:0] state,
  output logic       halted
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_e;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       alu;
    logic [1:0] acc;
    logic       jmp;
    logic       jz;
  } dec_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_IN  = 4'b1011;
  localparam logic [3:0] OP_STA = 4'b1101;
  localparam logic [3:0] OP_JZ  = 4'b1110;
  localparam logic [3:0] OP_LDI = 4'b1111;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_IMM  = 2'b01;
  localparam logic [1:0] ACC_ALU  = 2'b10;
  localparam logic [1:0] ACC_PORT = 2'b11;

  localparam logic [8:0] PROG_LEN_W = 9'(PROG_LEN);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       halted_q, halted_d;

  dec_t       dec;
  logic [8:0] pc_nx;

  // Opcode decode; undefined opcodes fall through to the all-zero NOP pattern.
  always_comb begin
    dec = '0;
    unique case (ir_q[7:4])
      OP_ADD, OP_SUB, OP_AND: begin
        dec.rd  = 1'b1;
        dec.alu = 1'b1;
        dec.acc = ACC_ALU;
      end
      OP_CMP: begin
        dec.rd  = 1'b1;
        dec.alu = 1'b1;
      end
      OP_LDI:  dec.acc = ACC_IMM;
      OP_IN:   dec.acc = ACC_PORT;
      OP_STA:  dec.wr  = 1'b1;
      OP_JMP:  dec.jmp = 1'b1;
      OP_JZ:   dec.jz  = 1'b1;
      default: dec = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    alu_en   = 1'b0;
    acc_load = ACC_NONE;
    pc_nx    = {1'b0, pc_q} + 9'd1;
    unique case (state_q)
      T0: if (run && !halted_q) state_d = T1;
      T1: begin
        ir_d    = prog_data;
        state_d = T2;
      end
      T2: begin
        ram_re  = dec.rd;
        state_d = T3;
      end
      T3: begin
        ram_we   = dec.wr;
        alu_en   = dec.alu;
        acc_load = dec.acc;
        if (dec.jmp || (dec.jz && zero_flag)) pc_nx = {5'h00, ir_q[3:0]};
        // Out-of-range PC is kept (not clamped) so the halt point stays visible.
        pc_d = pc_nx[7:0];
        if (pc_nx >= PROG_LEN_W) halted_d = 1'b1;
        state_d = T0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T0;
      pc_q     <= 8'h00;
      ir_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign prog_addr = pc_q;
  assign ram_addr  = ir_q[3:0];
  assign imm       = ir_q[3:0];
  assign alu_op    = ir_q[5:4];
  assign state     = state_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected T2/T3/next-T0 observations,
// a negedge monitor pops and compares them and also checks strobes stay quiet elsewhere.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, zero_flag;
  logic [7:0] prog_data;
  logic [7:0] prog_addr;
  logic [3:0] ram_addr, imm;
  logic       ram_re, ram_we, alu_en, halted;
  logic [1:0] alu_op, acc_load, state;

  int errors = 0;
  int checks = 0;

  // {state, ram_re, ram_we, alu_en, acc_load, alu_op, ram_addr, imm, prog_addr, halted}
  typedef logic [25:0] obs_t;
  obs_t       exp_q[$];
  logic [7:0] cur_pc;

  control_sequencer #(.PROG_LEN(28)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_data(prog_data), .zero_flag(zero_flag),
    .prog_addr(prog_addr), .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .imm(imm), .alu_op(alu_op), .alu_en(alu_en), .acc_load(acc_load),
    .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic [1:0] st, input logic re, input logic we,
                              input logic al, input logic [1:0] acc, input logic [7:0] ins,
                              input logic [7:0] pc, input logic h);
    return {st, re, we, al, acc, ins[5:4], ins[3:0], ins[3:0], pc, h};
  endfunction

  // Monitor: T2, T3 and the T0 that follows T3 are the observable instruction events.
  logic [1:0] prev_state = 2'bxx;
  always @(negedge clk) begin
    obs_t act, e;
    act = {state, ram_re, ram_we, alu_en, acc_load, alu_op, ram_addr, imm, prog_addr, halted};
    if (state == 2'd2 || state == 2'd3 || (state == 2'd0 && prev_state == 2'd3)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL event_st%0d: got %h expected %h", state, act, e);
        end
      end
    end else begin
      chk("quiet_strobes", {27'd0, ram_re, ram_we, alu_en, acc_load}, 32'd0);
    end
    prev_state = state;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [7:0] ins, input logic zf, input logic re, input logic al,
                      input logic [1:0] acc, input logic we, input logic [7:0] npc,
                      input logic nh, input logic drop_run);
    prog_data = ins;
    zero_flag = zf;
    run       = 1'b1;
    exp_q.push_back(mk(2'd2, re, 1'b0, 1'b0, 2'b00, ins, cur_pc, 1'b0));
    exp_q.push_back(mk(2'd3, 1'b0, we, al, acc, ins, cur_pc, 1'b0));
    exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 2'b00, ins, npc, nh));
    step();
    chk("fetch_to_t1", {30'd0, state}, 32'd1);
    if (drop_run) run = 1'b0;
    step();
    step();
    step();
    cur_pc = npc;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; zero_flag = 1'b0; prog_data = 8'h00;
    cur_pc = 8'h00;
    step();
    step();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_pc", {24'd0, prog_addr}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    //   ins    zf    re    alu   acc    we    npc    halt  drop
    exec(8'hF1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 8'd1,  1'b0, 1'b0); // LDI 1
    exec(8'h11, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 8'd2,  1'b0, 1'b0); // ADD R1
    exec(8'h25, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 8'd3,  1'b0, 1'b1); // SUB R5, run dropped
    step();
    chk("run_drop_wait_state", {30'd0, state}, 32'd0);
    chk("run_drop_wait_pc", {24'd0, prog_addr}, 32'd3);
    exec(8'h37, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 8'd4,  1'b0, 1'b0); // AND R7
    exec(8'h6A, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 8'd5,  1'b0, 1'b0); // CMP RA
    exec(8'hB0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 8'd6,  1'b0, 1'b0); // IN
    exec(8'hD3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'd7,  1'b0, 1'b0); // STA R3
    exec(8'h45, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd8,  1'b0, 1'b0); // undefined -> NOP
    exec(8'hE8, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd8,  1'b0, 1'b0); // JZ 8 taken
    exec(8'hE8, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd9,  1'b0, 1'b0); // JZ 8 not taken
    exec(8'h9A, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd10, 1'b0, 1'b0); // JMP 10
    exec(8'h0F, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd11, 1'b0, 1'b0); // NOP

    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_state", {30'd0, state}, 32'd0);
      chk("hold_pc", {24'd0, prog_addr}, 32'd11);
    end

    exec(8'h9F, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd15, 1'b0, 1'b0); // JMP 15
    for (int p = 15; p < 28; p++)
      exec(8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'(p + 1), (p == 27), 1'b0);

    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_state", {30'd0, state}, 32'd0);
      chk("halt_pc", {24'd0, prog_addr}, 32'd28);
      chk("halt_flag", {31'd0, halted}, 32'd1);
    end

    // Reset during T2 of STA: the T3 write must never happen.
    rst = 1'b1; step(); rst = 1'b0;
    cur_pc = 8'h00;
    prog_data = 8'hD3;
    exp_q.push_back(mk(2'd2, 1'b0, 1'b0, 1'b0, 2'b00, 8'hD3, 8'h00, 1'b0));
    step();
    step();
    chk("abort_in_t2", {30'd0, state}, 32'd2);
    rst = 1'b1;
    run = 1'b0;
    step();
    rst = 1'b0;
    chk("abort_state", {30'd0, state}, 32'd0);
    chk("abort_pc", {24'd0, prog_addr}, 32'd0);
    chk("abort_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_we", {31'd0, ram_we}, 32'd0);
    end

    step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
